// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use/branch stalls, divider
// handshake FSM, exception flushing and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteE,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic              memtoregE,
  input  logic              memtoregM,
  input  logic              branchD,
  input  logic              divE,
  input  logic              div_done,
  input  logic              except_M,
  input  logic              cnt_clr,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              forwardAD,
  output logic              forwardBD,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              div_start,
  output logic              div_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lwstall, brstall, divhold;
  logic             e_hits_d, m_hits_d;

  // Register 0 is hard-wired, so it never forwards and never causes a stall.
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (rsE != '0) begin
      if (regwriteM && (rsE == writeregM))      forwardAE = 2'b10;
      else if (regwriteW && (rsE == writeregW)) forwardAE = 2'b01;
    end
    if (rtE != '0) begin
      if (regwriteM && (rtE == writeregM))      forwardBE = 2'b10;
      else if (regwriteW && (rtE == writeregW)) forwardBE = 2'b01;
    end
  end

  assign forwardAD = (rsD != '0) && regwriteM && (rsD == writeregM);
  assign forwardBD = (rtD != '0) && regwriteM && (rtD == writeregM);

  assign e_hits_d = (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD));
  assign m_hits_d = (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD));

  assign lwstall = memtoregE && e_hits_d;
  assign brstall = branchD && ((regwriteE && e_hits_d) || (memtoregM && m_hits_d));
  assign divhold = ((state_q == IDLE) && divE) || (state_q == BUSY);

  always_comb begin
    state_d   = state_q;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;
    div_start = 1'b0;

    if (except_M) begin
      state_d = IDLE;
      flushD  = 1'b1;
      flushE  = 1'b1;
      flushM  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE:    if (divE) state_d = BUSY;
        BUSY:    if (div_done) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase

      if (divhold) begin
        // Hold everything up to E; bubble M so the divide is not duplicated.
        stallF    = 1'b1;
        stallD    = 1'b1;
        stallE    = 1'b1;
        flushM    = 1'b1;
        div_start = (state_q == IDLE);
      end else begin
        stallF = lwstall || brstall;
        stallD = lwstall || brstall;
        flushE = lwstall || brstall;
      end
    end
  end

  assign div_busy = (state_q != IDLE);

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                    cnt_d = '0;
    else if (stallF && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  assign stall_cnt = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int unsigned CW   = 3;
  localparam int          CMAX = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic       branchD, divE, div_done, except_M, cnt_clr;
  logic [1:0] forwardAE, forwardBE;
  logic       forwardAD, forwardBD;
  logic       stallF, stallD, stallE, flushD, flushE, flushM;
  logic       div_start, div_busy;
  logic [CW-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: a divide handed to the divider and awaiting its result,
  // or a divide whose result arrived and is leaving E this cycle.
  bit m_waiting, m_leaving;
  int m_cnt;
  bit nx_waiting, nx_leaving;
  int nx_cnt;

  hazard_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .divE(divE), .div_done(div_done),
    .except_M(except_M), .cnt_clr(cnt_clr),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .div_start(div_start), .div_busy(div_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] s);
    if (s == 5'd0) return 2'b00;
    if (regwriteM && s == writeregM) return 2'b10;
    if (regwriteW && s == writeregW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit reads(input logic [4:0] d);
    return (d != 5'd0) && (d == rsD || d == rtD);
  endfunction

  task automatic clear_inputs();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
    {branchD, divE, div_done, except_M, cnt_clr} = '0;
  endtask

  // Compare all outputs for the current cycle against the model and work out
  // the model's state after the coming clock edge.
  task automatic check_now();
    bit idle, hold, lw, br, hz;
    bit sF, sD, sE, fD, fE, fM, st;
    logic [1:0] eA, eB;
    bit eAD, eBD;
    #1;
    idle = !m_waiting && !m_leaving;
    hold = (idle && divE) || m_waiting;
    lw   = memtoregE && reads(writeregE);
    br   = branchD && ((regwriteE && reads(writeregE)) || (memtoregM && reads(writeregM)));
    hz   = lw || br;
    {sF, sD, sE, fD, fE, fM, st} = '0;
    if (except_M) begin
      {fD, fE, fM} = 3'b111;
    end else if (hold) begin
      {sF, sD, sE, fM} = 4'b1111;
      st = idle;
    end else begin
      sF = hz; sD = hz; fE = hz;
    end
    eA  = exp_fwd(rsE);
    eB  = exp_fwd(rtE);
    eAD = (rsD != 5'd0) && regwriteM && (rsD == writeregM);
    eBD = (rtD != 5'd0) && regwriteM && (rtD == writeregM);

    check("fwd", 32'({forwardAE, forwardBE, forwardAD, forwardBD}), 32'({eA, eB, eAD, eBD}));
    check("ctl", 32'({stallF, stallD, stallE, flushD, flushE, flushM}),
          32'({sF, sD, sE, fD, fE, fM}));
    check("div", 32'({div_start, div_busy}), 32'({st, m_waiting | m_leaving}));
    check("cnt", 32'(stall_cnt), 32'(m_cnt));

    nx_waiting = m_waiting;
    nx_leaving = m_leaving;
    if (except_M) begin
      nx_waiting = 0; nx_leaving = 0;
    end else if (m_waiting) begin
      if (div_done) begin nx_waiting = 0; nx_leaving = 1; end
    end else if (m_leaving) begin
      nx_leaving = 0;
    end else if (divE) begin
      nx_waiting = 1;
    end
    if (cnt_clr)  nx_cnt = 0;
    else if (sF)  nx_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    else          nx_cnt = m_cnt;
  endtask

  task automatic advance();
    @(posedge clk);
    m_waiting = nx_waiting;
    m_leaving = nx_leaving;
    m_cnt     = nx_cnt;
    @(negedge clk);
  endtask

  task automatic cycle();
    check_now();
    advance();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    m_waiting = 0; m_leaving = 0; m_cnt = 0;
    @(negedge clk); @(negedge clk); #1;
    check("rst_out", 32'({forwardAE, forwardBE, forwardAD, forwardBD, stallF, stallD, stallE,
                         flushD, flushE, flushM, div_start, div_busy}), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Forwarding priority and register 0
    rsE = 3; rtE = 3; writeregM = 3; writeregW = 3; regwriteM = 1; regwriteW = 1;
    check_now(); check("fwdM", 32'({forwardAE, forwardBE}), 32'({2'b10, 2'b10})); advance();
    regwriteM = 0;
    check_now(); check("fwdW", 32'({forwardAE, forwardBE}), 32'({2'b01, 2'b01})); advance();
    rsE = 0; rtE = 0; writeregM = 0; writeregW = 0; regwriteM = 1;
    check_now(); check("fwd0", 32'({forwardAE, forwardBE}), 32'd0); advance();
    clear_inputs();

    // Load-use
    memtoregE = 1; writeregE = 8; rtD = 8;
    check_now(); check("lw", 32'({stallF, stallD, flushE}), 32'b111); advance();
    writeregE = 0; rtD = 0;
    check_now(); check("lw0", 32'({stallF, stallD, flushE}), 32'b000); advance();
    clear_inputs();

    // Branch stalls on E writer, then on M load; M ALU result forwards instead
    branchD = 1; regwriteE = 1; writeregE = 5; rsD = 5; cycle();
    regwriteE = 0; writeregE = 0; memtoregM = 1; writeregM = 5; cycle();
    memtoregM = 0; regwriteM = 1;
    check_now(); check("br_fwd", 32'({stallF, forwardAD}), 32'b01); advance();
    clear_inputs();

    // Divide handshake with a masked load-use in T+2 and div_done at T+4
    divE = 1;
    for (int unsigned t = 0; t < 7; t++) begin
      memtoregE = (t == 2); writeregE = (t == 2) ? 5'd8 : 5'd0; rtD = (t == 2) ? 5'd8 : 5'd0;
      div_done = (t == 4);
      if (t == 6) divE = 0;
      check_now();
      if (t == 5) check("div_done_st", 32'({stallF, div_busy}), 32'b01);
      advance();
    end
    clear_inputs();

    // Exception aborts a divide; a late div_done is ignored
    divE = 1;
    for (int unsigned t = 0; t < 5; t++) begin
      except_M = (t == 2);
      div_done = (t == 4);
      if (t == 3) divE = 0;
      check_now();
      if (t == 3) check("exc_idle", 32'(div_busy), 32'd0);
      advance();
    end
    clear_inputs();

    // Saturating counter, synchronous clear, asynchronous reset mid-divide
    cnt_clr = 1; cycle(); cnt_clr = 0;
    memtoregE = 1; writeregE = 8; rtD = 8;
    for (int unsigned t = 0; t < 10; t++) cycle();
    clear_inputs();
    check_now(); check("cnt_sat", 32'(stall_cnt), 32'(CMAX)); advance();
    cnt_clr = 1; cycle(); cnt_clr = 0;
    check_now(); check("cnt_clr", 32'(stall_cnt), 32'd0); advance();
    divE = 1; cycle(); cycle(); cycle();
    #2 rst = 1'b1;
    clear_inputs();
    #1 check("arst", 32'({stall_cnt, div_busy}), 32'd0);
    m_waiting = 0; m_leaving = 0; m_cnt = 0;
    #1 rst = 1'b0;
    @(negedge clk);

    // Random traffic on a small register range to provoke matches
    for (int unsigned n = 0; n < 3000; n++) begin
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3));
      writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom_range(0, 1)); regwriteM = 1'($urandom_range(0, 1));
      regwriteW = 1'($urandom_range(0, 1));
      memtoregE = ($urandom_range(0, 3) == 0); memtoregM = ($urandom_range(0, 3) == 0);
      branchD   = ($urandom_range(0, 2) == 0);
      divE      = ($urandom_range(0, 3) == 0) || m_waiting;
      div_done  = ($urandom_range(0, 3) == 0);
      except_M  = ($urandom_range(0, 15) == 0);
      cnt_clr   = ($urandom_range(0, 31) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
